// File: rtl/regbank_pkg.sv
// regbank_pkg: shared sizes for the register bank and the ALU control stage.
//   DATA_W   register width
//   ADDR_W   register index width
//   NUM_REGS number of architectural registers (R0..R15)
//   PC_IDX   index of the program counter register (R15)
package regbank_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  localparam logic [ADDR_W-1:0] PC_IDX = 4'd15;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/register_bank_pc_counter.sv
// pc_counter: holds R15 (the program counter) and its next-value logic.
//   clk, rst_n  clock and asynchronous active-low reset (loads RESET_PC)
//   wr_en       register write strobe from the bank write port
//   wr_addr     write index; only index PC_IDX affects this block
//   wr_data     write data
//   pc_inc      advance the PC by PC_STEP this cycle
//   pc          current PC value
// A write to R15 wins over an increment in the same cycle.
module pc_counter
  import regbank_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    PC_STEP  = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  word_t wr_data,
  input  logic  pc_inc,
  output word_t pc
);

  logic wr_hit;

  assign wr_hit = wr_en && (wr_addr == PC_IDX);

  // The addition is naturally modulo 2^32, so the PC wraps past 0xFFFF_FFFC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (wr_hit) begin
      pc <= wr_data;
    end else if (pc_inc) begin
      pc <= pc + word_t'(PC_STEP);
    end
  end

endmodule

// File: rtl/register_bank.sv
// register_bank: 16 x 32-bit register file (R15 = PC) with registered Z/N flags.
//   clk, rst_n            clock and asynchronous active-low reset
//   rh_addr / rh_value    read port A (ALU A operand), combinational
//   ro_addr / ro_value    read port B (ALU B operand), combinational
//   wr_en, wr_addr,
//   wr_data               synchronous write port
//   pc_inc                advance R15 by PC_STEP
//   pc_value              current R15
//   flags_we, zero_in,
//   negative_in           flag capture strobe and ALU flag inputs
//   flag_z, flag_n        registered condition flags
// Optional build macro REGBANK_BYPASS_EN: a read port addressing the register
// being written this cycle returns wr_data (write-through, R15 included).
// Without it, such a read returns the stored (pre-write) value.
module register_bank
  import regbank_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    PC_STEP  = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  addr_t rh_addr,
  input  addr_t ro_addr,
  output word_t rh_value,
  output word_t ro_value,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  word_t wr_data,
  input  logic  pc_inc,
  input  logic  flags_we,
  input  logic  zero_in,
  input  logic  negative_in,
  output word_t pc_value,
  output logic  flag_z,
  output logic  flag_n
);

  // R0..R14; R15 lives in pc_counter.
  word_t gpr [NUM_REGS-1];
  word_t pc_q;
  word_t rh_stored;
  word_t ro_stored;

  pc_counter #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .pc_inc  (pc_inc),
    .pc      (pc_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        gpr[i] <= '0;
      end
    end else if (wr_en && (wr_addr != PC_IDX)) begin
      gpr[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (flags_we) begin
      flag_z <= zero_in;
      flag_n <= negative_in;
    end
  end

  always_comb begin
    rh_stored = '0;
    ro_stored = '0;
    if (rh_addr == PC_IDX) rh_stored = pc_q;
    else                   rh_stored = gpr[rh_addr];
    if (ro_addr == PC_IDX) ro_stored = pc_q;
    else                   ro_stored = gpr[ro_addr];
  end

`ifdef REGBANK_BYPASS_EN
  // Forwarding is suppressed during reset so the read ports show the cleared state.
  assign rh_value = (rst_n && wr_en && (wr_addr == rh_addr)) ? wr_data : rh_stored;
  assign ro_value = (rst_n && wr_en && (wr_addr == ro_addr)) ? wr_data : ro_stored;
`else
  assign rh_value = rh_stored;
  assign ro_value = ro_stored;
`endif

  assign pc_value = pc_q;

endmodule
